// File: rtl/atm_pkg.sv
// atm_pkg: shared constants for the ATM keypad front end.
//   - FSM state encoding (fe_state_t)
//   - core option codes, keypad codes
//   - per-field maximum value and digit-count limits for the accumulator
package atm_pkg;

    typedef enum logic [3:0] {
        ST_ACC   = 4'd0,
        ST_PIN   = 4'd1,
        ST_MENU  = 4'd2,
        ST_AMT   = 4'd3,
        ST_DEST  = 4'd4,
        ST_ISSUE = 4'd5,
        ST_WAIT  = 4'd6
    } fe_state_t;

    localparam logic [2:0] OPT_BALANCE               = 3'd3;
    localparam logic [2:0] OPT_WITHDRAW              = 3'd4;
    localparam logic [2:0] OPT_WITHDRAW_SHOW_BALANCE = 3'd5;
    localparam logic [2:0] OPT_TRANSACTION           = 3'd6;
    localparam logic [2:0] OPT_DEPOSIT               = 3'd7;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ENTER     = 4'hA;
    localparam logic [3:0] KEY_CANCEL    = 4'hB;
    localparam logic [3:0] KEY_CLEAR     = 4'hC;

    // Working register is 17 bits wide; limits are expressed at that width.
    localparam logic [16:0] MAX_ACC = 17'd4095;
    localparam logic [16:0] MAX_PIN = 17'd15;
    localparam logic [16:0] MAX_AMT = 17'd2047;
    localparam logic [16:0] MAX_OPT = 17'd7;

    localparam logic [2:0] DIG_ACC = 3'd4;
    localparam logic [2:0] DIG_PIN = 3'd2;
    localparam logic [2:0] DIG_AMT = 3'd4;
    localparam logic [2:0] DIG_OPT = 3'd1;

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// atm_keypad_frontend_if: request/response bus between the keypad front end
// and the ATM core.
//   master (front end): drives the request fields, atm_op_valid, atm_exit;
//                       receives atm_error, atm_balance.
//   slave  (core)     : the mirror image.
// Handshake: atm_op_valid is a one-cycle strobe; the request fields are stable
// while it is high and until the next load or cancel. There is no ready; the
// core answers RESP_LAT cycles later on atm_error/atm_balance.
interface atm_keypad_frontend_if;
    logic [11:0] atm_acc_number;
    logic [3:0]  atm_pin;
    logic [11:0] atm_dest_acc_number;
    logic [2:0]  atm_menu_option;
    logic [10:0] atm_amount;
    logic        atm_op_valid;
    logic        atm_exit;
    logic        atm_error;
    logic [10:0] atm_balance;

    modport master (
        output atm_acc_number, atm_pin, atm_dest_acc_number, atm_menu_option,
               atm_amount, atm_op_valid, atm_exit,
        input  atm_error, atm_balance
    );

    modport slave (
        input  atm_acc_number, atm_pin, atm_dest_acc_number, atm_menu_option,
               atm_amount, atm_op_valid, atm_exit,
        output atm_error, atm_balance
    );
endinterface

// File: rtl/atm_fe_digit_acc.sv
// atm_fe_digit_acc: decimal entry accumulator (val = val*10 + digit).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        zero value, digit count and overflow flag (wins over digit)
//   digit_valid  accumulate digit this cycle
//   digit        decimal digit 0-9
//   max_value    largest legal value of the field being entered
//   max_digits   largest legal digit count of the field being entered
//   value        working register
//   count        digits accepted so far
//   ovf          sticky overflow: too many digits or value above max_value
module atm_fe_digit_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic [16:0] max_value,
    input  logic [2:0]  max_digits,
    output logic [16:0] value,
    output logic [2:0]  count,
    output logic        ovf
);
    logic [16:0] next_value;

    // With at most 4 digits stored, value*10+9 stays below 2^17.
    assign next_value = value * 17'd10 + {13'd0, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (digit_valid) begin
            if (count >= max_digits) begin
                // Digit dropped; only the flag records it.
                ovf <= 1'b1;
            end else begin
                value <= next_value;
                count <= count + 3'd1;
                if (next_value > max_value) ovf <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/atm_keypad_frontend.sv
// atm_keypad_frontend: turns keypad strobes into ATM core requests.
// Optional feature macro: ATM_FE_TIMEOUT_EN (inactivity timeout acting as CANCEL).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   key_valid/key_code  one-cycle key strobe; 0-9 digit, A enter, B cancel,
//                       C clear, D-F ignored
//   core                request/response bus to the ATM core (master side)
//   disp_balance        balance latched from the core
//   disp_error          sticky error, cleared by the next accepted key
//   busy                high in ISSUE and WAIT; keys are dropped then
//   state               current FSM state
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int RESP_LAT       = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid,
    input  logic [3:0]             key_code,
    atm_keypad_frontend_if.master  core,
    output logic [10:0]            disp_balance,
    output logic                   disp_error,
    output logic                   busy,
    output logic [3:0]             state
);
    fe_state_t   st;
    logic [3:0]  wait_cnt;
    logic [16:0] acc_value;
    logic [2:0]  acc_count;
    logic        acc_ovf;
    logic [16:0] lim_value;
    logic [2:0]  lim_digits;
    logic        key_acc, is_digit, is_enter, is_clear, is_cancel;
    logic        entry_ok, timeout_hit;
    logic        unused_acc_hi;

    assign busy      = (st == ST_ISSUE) || (st == ST_WAIT);
    assign state     = st;
    assign key_acc   = key_valid && !busy && (key_code <= KEY_CLEAR);
    assign is_digit  = key_acc && (key_code <= KEY_DIGIT_MAX);
    assign is_enter  = key_acc && (key_code == KEY_ENTER);
    assign is_clear  = key_acc && (key_code == KEY_CLEAR);
    assign is_cancel = (key_acc && (key_code == KEY_CANCEL)) || timeout_hit;
    assign entry_ok  = !acc_ovf && (acc_count != 3'd0);
    // Loaded fields are at most 12 bits; upper working bits only feed ovf.
    assign unused_acc_hi = ^acc_value[16:12];

`ifdef ATM_FE_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        active;

    assign active      = (st == ST_PIN) || (st == ST_MENU) || (st == ST_AMT) || (st == ST_DEST);
    assign timeout_hit = active && !key_acc && (idle_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              idle_cnt <= '0;
        else if (!active || key_acc || timeout_hit) idle_cnt <= '0;
        else                                     idle_cnt <= idle_cnt + 16'd1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        lim_value  = MAX_ACC;
        lim_digits = DIG_ACC;
        case (st)
            ST_PIN:  begin lim_value = MAX_PIN; lim_digits = DIG_PIN; end
            ST_MENU: begin lim_value = MAX_OPT; lim_digits = DIG_OPT; end
            ST_AMT:  begin lim_value = MAX_AMT; lim_digits = DIG_AMT; end
            default: ;
        endcase
    end

    // Every ENTER empties the working register, valid or not.
    atm_fe_digit_acc u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (is_clear || is_enter || is_cancel),
        .digit_valid (is_digit),
        .digit       (key_code),
        .max_value   (lim_value),
        .max_digits  (lim_digits),
        .value       (acc_value),
        .count       (acc_count),
        .ovf         (acc_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st                       <= ST_ACC;
            wait_cnt                 <= '0;
            core.atm_acc_number      <= '0;
            core.atm_pin             <= '0;
            core.atm_dest_acc_number <= '0;
            core.atm_menu_option     <= '0;
            core.atm_amount          <= '0;
            core.atm_op_valid        <= 1'b0;
            core.atm_exit            <= 1'b0;
            disp_balance             <= '0;
            disp_error               <= 1'b0;
        end else begin
            core.atm_op_valid <= 1'b0;
            core.atm_exit     <= 1'b0;
            if (key_acc) disp_error <= 1'b0;

            if (is_cancel) begin
                core.atm_exit            <= 1'b1;
                core.atm_acc_number      <= '0;
                core.atm_pin             <= '0;
                core.atm_dest_acc_number <= '0;
                core.atm_menu_option     <= '0;
                core.atm_amount          <= '0;
                st                       <= ST_ACC;
            end else begin
                case (st)
                    ST_ACC: if (is_enter) begin
                        if (!entry_ok) disp_error <= 1'b1;
                        else begin
                            core.atm_acc_number <= acc_value[11:0];
                            st                  <= ST_PIN;
                        end
                    end
                    ST_PIN: if (is_enter) begin
                        if (!entry_ok) disp_error <= 1'b1;
                        else begin
                            core.atm_pin <= acc_value[3:0];
                            st           <= ST_MENU;
                        end
                    end
                    ST_MENU: if (is_enter) begin
                        if (!entry_ok) disp_error <= 1'b1;
                        else begin
                            case (acc_value[2:0])
                                OPT_BALANCE: begin
                                    core.atm_menu_option <= OPT_BALANCE;
                                    core.atm_op_valid    <= 1'b1;
                                    st                   <= ST_ISSUE;
                                end
                                OPT_WITHDRAW, OPT_WITHDRAW_SHOW_BALANCE,
                                OPT_TRANSACTION, OPT_DEPOSIT: begin
                                    core.atm_menu_option <= acc_value[2:0];
                                    st                   <= ST_AMT;
                                end
                                default: disp_error <= 1'b1;
                            endcase
                        end
                    end
                    ST_AMT: if (is_enter) begin
                        if (!entry_ok) disp_error <= 1'b1;
                        else begin
                            core.atm_amount <= acc_value[10:0];
                            if (core.atm_menu_option == OPT_TRANSACTION) begin
                                st <= ST_DEST;
                            end else begin
                                core.atm_op_valid <= 1'b1;
                                st                <= ST_ISSUE;
                            end
                        end
                    end
                    ST_DEST: if (is_enter) begin
                        if (!entry_ok) disp_error <= 1'b1;
                        else begin
                            core.atm_dest_acc_number <= acc_value[11:0];
                            core.atm_op_valid        <= 1'b1;
                            st                       <= ST_ISSUE;
                        end
                    end
                    // The strobe was raised on entry, so it is high exactly here.
                    ST_ISSUE: begin
                        wait_cnt <= 4'd1;
                        st       <= ST_WAIT;
                    end
                    // WAIT lasts RESP_LAT cycles; sample on the last one.
                    ST_WAIT: begin
                        if (wait_cnt == 4'(RESP_LAT)) begin
                            disp_balance <= core.atm_balance;
                            disp_error   <= core.atm_error;
                            st           <= ST_MENU;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    default: st <= ST_ACC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_atm_keypad_frontend.sv
module tb_atm_keypad_frontend;
    localparam int R  = 2;
    localparam int TO = 20;
    localparam int PH_ACC = 0, PH_PIN = 1, PH_MENU = 2, PH_AMT = 3, PH_DEST = 4;

    logic        clk, rst_n, key_valid;
    logic [3:0]  key_code;
    logic [10:0] disp_balance;
    logic        disp_error, busy;
    logic [3:0]  state;

    atm_keypad_frontend_if bus();

    atm_keypad_frontend #(.RESP_LAT(R), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .core(bus), .disp_balance(disp_balance), .disp_error(disp_error),
        .busy(busy), .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard queues
    logic [41:0] exp_q[$];   // {option, acc, pin, amount, dest}
    logic [11:0] resp_q[$];  // {error, balance} the core model will return
    int          exit_pend = 0;

    // reference model state (session-level view)
    int          m_phase = PH_ACC;
    int          m_typed[$];
    logic [11:0] m_acc = 0, m_dest = 0;
    logic [3:0]  m_pin = 0;
    logic [2:0]  m_opt = 0;
    logic [10:0] m_amt = 0, m_dbal = 0;
    logic        m_derr = 0;
    int          m_busy = 0;
    int          m_idle = 0;
    int          dir_bal = -1, dir_err = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit typed_value(output longint val);
        int maxd;
        longint maxv;
        case (m_phase)
            PH_PIN:  begin maxd = 2; maxv = 15;   end
            PH_MENU: begin maxd = 1; maxv = 7;    end
            PH_AMT:  begin maxd = 4; maxv = 2047; end
            default: begin maxd = 4; maxv = 4095; end
        endcase
        val = 0;
        foreach (m_typed[i]) val = val * 10 + m_typed[i];
        return (m_typed.size() >= 1) && (m_typed.size() <= maxd) && (val <= maxv);
    endfunction

    task automatic model_cancel();
        exit_pend++;
        m_acc = 0; m_pin = 0; m_dest = 0; m_opt = 0; m_amt = 0;
        m_typed.delete();
        m_phase = PH_ACC;
        m_idle  = 0;
    endtask

    task automatic model_issue();
        logic [10:0] bal;
        logic        err;
        bal = (dir_bal >= 0) ? 11'(dir_bal) : 11'($urandom_range(0, 2047));
        err = (dir_err >= 0) ? 1'(dir_err) : 1'($urandom_range(0, 1));
        exp_q.push_back({m_opt, m_acc, m_pin, m_amt, m_dest});
        resp_q.push_back({err, bal});
        m_dbal = bal; m_derr = err;
        m_phase = PH_MENU;
        m_busy  = R + 1;
        dir_bal = -1; dir_err = -1;
    endtask

    task automatic model_step(input logic v, input logic [3:0] c);
        bit     acc_k, ok;
        longint val;
        if (m_busy > 0) begin m_busy--; m_idle = 0; return; end
        acc_k = v && (c <= 4'hC);
`ifdef ATM_FE_TIMEOUT_EN
        if (m_phase != PH_ACC) begin
            if (acc_k) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TO) begin model_cancel(); return; end
            end
        end else m_idle = 0;
`endif
        if (!acc_k) return;
        m_derr = 0;
        if (c <= 4'd9) m_typed.push_back(int'(c));
        else if (c == 4'hC) m_typed.delete();
        else if (c == 4'hB) model_cancel();
        else begin
            ok = typed_value(val);
            m_typed.delete();
            if (!ok) m_derr = 1;
            else case (m_phase)
                PH_ACC:  begin m_acc = val[11:0]; m_phase = PH_PIN; end
                PH_PIN:  begin m_pin = val[3:0]; m_phase = PH_MENU; end
                PH_MENU: begin
                    if (val < 3) m_derr = 1;
                    else begin
                        m_opt = val[2:0];
                        if (val == 3) model_issue();
                        else m_phase = PH_AMT;
                    end
                end
                PH_AMT: begin
                    m_amt = val[10:0];
                    if (m_opt == 3'd6) m_phase = PH_DEST;
                    else model_issue();
                end
                default: begin m_dest = val[11:0]; model_issue(); end
            endcase
        end
    endtask

    // driver tasks: called at posedge+1, return at the next posedge+1
    task automatic tick(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        model_step(v, c);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
    endtask

    task automatic send_str(input string s);
        byte ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch >= 8'h30 && ch <= 8'h39) tick(1'b1, 4'(ch - 8'h30));
            else tick(1'b1, 4'(ch - 8'h41 + 10));
        end
    endtask

    task automatic checkpoint(input string tag);
        if (m_busy != 0) return;
        check({tag, ":state"},  64'(state), 64'(m_phase));
        check({tag, ":acc"},    bus.atm_acc_number, m_acc);
        check({tag, ":pin"},    bus.atm_pin, m_pin);
        check({tag, ":opt"},    bus.atm_menu_option, m_opt);
        check({tag, ":amt"},    bus.atm_amount, m_amt);
        check({tag, ":dest"},   bus.atm_dest_acc_number, m_dest);
        check({tag, ":derr"},   disp_error, m_derr);
        check({tag, ":dbal"},   disp_balance, m_dbal);
        check({tag, ":busy"},   busy, 1'b0);
    endtask

    // monitor + core model
    initial begin : monitor
        logic [41:0] exp_req;
        logic [11:0] rsp;
        bus.atm_balance = '0;
        bus.atm_error   = 1'b0;
        forever begin
            @(negedge clk);
            bus.atm_balance = 11'($urandom_range(0, 2047));
            bus.atm_error   = 1'($urandom_range(0, 1));
            if (rst_n) begin
                if (bus.atm_exit) begin
                    check("exit_expected", 64'(exit_pend > 0), 64'd1);
                    if (exit_pend > 0) exit_pend--;
                    check("exit_fields", {bus.atm_acc_number, bus.atm_pin, bus.atm_menu_option,
                                          bus.atm_amount, bus.atm_dest_acc_number}, 64'd0);
                    check("exit_state", 64'(state), 64'(PH_ACC));
                end
                if (bus.atm_op_valid) begin
                    check("op_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        exp_req = exp_q.pop_front();
                        check("request", {bus.atm_menu_option, bus.atm_acc_number, bus.atm_pin,
                                          bus.atm_amount, bus.atm_dest_acc_number}, exp_req);
                    end
                    rsp = (resp_q.size() != 0) ? resp_q.pop_front() : 12'd0;
                    check("issue_busy", {busy, state}, {1'b1, 4'd5});
                    for (int k = 1; k <= R; k++) begin
                        @(negedge clk);
                        if (k == R) begin
                            bus.atm_balance = rsp[10:0];
                            bus.atm_error   = rsp[11];
                        end else begin
                            bus.atm_balance = 11'($urandom_range(0, 2047));
                            bus.atm_error   = 1'($urandom_range(0, 1));
                        end
                        check("wait_busy", {busy, state, bus.atm_op_valid}, {1'b1, 4'd6, 1'b0});
                    end
                    @(negedge clk);
                    bus.atm_balance = 11'($urandom_range(0, 2047));
                    bus.atm_error   = 1'($urandom_range(0, 1));
                    check("resp_balance", disp_balance, rsp[10:0]);
                    check("resp_error",   disp_error, rsp[11]);
                    check("resp_state",   {busy, state}, {1'b0, 4'd2});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // stimulus
    initial begin : stimulus
        int r;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   64'(state), 64'd0);
        check("rst_fields",  {bus.atm_acc_number, bus.atm_pin, bus.atm_menu_option,
                              bus.atm_amount, bus.atm_dest_acc_number}, 64'd0);
        check("rst_strobes", {bus.atm_op_valid, bus.atm_exit, busy}, 64'd0);
        check("rst_disp",    {disp_balance, disp_error}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_str("2178A4A");         checkpoint("login");
        check("login_acc", bus.atm_acc_number, 12'd2178);
        dir_bal = 1900; dir_err = 0;
        send_str("5A100A");          idle(R + 2); checkpoint("withdraw_show");
        check("bal_1900", disp_balance, 11'd1900);
        send_str("4A2550A");         checkpoint("amt_overflow");
        check("amt_ovf_err", {disp_error, state}, {1'b1, 4'd3});
        send_str("C50A");            idle(R + 2); checkpoint("amt_50");
        send_str("6A50A2816A");
        send_str("9B1");             idle(R + 2); checkpoint("transfer");
        check("dest_2816", bus.atm_dest_acc_number, 12'd2816);
        send_str("B");               idle(1); checkpoint("cancel_menu");
        send_str("2816A6A3A");       idle(R + 2); checkpoint("relogin_balance");
        send_str("A");               checkpoint("enter_empty");
        send_str("0A");              checkpoint("opt_zero");
        send_str("9A");              checkpoint("opt_nine");
        send_str("DEF");             checkpoint("ignored_keys");
        send_str("B4095A15A");       checkpoint("max_acc_pin");
        send_str("B1A16A");          checkpoint("pin_16");
        send_str("123A");            checkpoint("pin_3dig");
        send_str("7A");              checkpoint("opt7");
        send_str("B1A1A");           idle(TO + 5); checkpoint("idle");
`ifdef ATM_FE_TIMEOUT_EN
        check("idle_state", 64'(state), 64'(PH_ACC));
`else
        check("idle_state", 64'(state), 64'(PH_MENU));
`endif

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      tick(1'b1, 4'($urandom_range(0, 9)));
            else if (r < 70) tick(1'b1, 4'hA);
            else if (r < 73) tick(1'b1, 4'hB);
            else if (r < 77) tick(1'b1, 4'hC);
            else if (r < 80) tick(1'b1, 4'($urandom_range(13, 15)));
            else             tick(1'b0, 4'($urandom_range(0, 15)));
            checkpoint("random");
        end

        idle(R + 3);
        check("exp_q_empty",  64'(exp_q.size()), 64'd0);
        check("exit_pending", 64'(exit_pend), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Customer-side front end that drives the ATM core. It turns a stream of single-cycle keypad strobes into the ATM core's request fields: account number, PIN, menu option, amount and destination account. It issues each request to the core with a one-cycle strobe, captures the core's `error`/`balance` response for display, and issues session exit on cancel.

## Interface
Parameters:
- `RESP_LAT`, default 2: cycles from `atm_op_valid` to sampling `atm_error`/`atm_balance`; legal range 1–15.
- `TIMEOUT_CYCLES`, default 1000: inactivity limit. Used only with `ATM_FE_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle key strobe.
- `key_code`  in  4  key value: 0–9 digit, 4'hA ENTER, 4'hB CANCEL, 4'hC CLEAR; 4'hD–F are ignored.
- `atm_acc_number`  out  12  account number presented to the core.
- `atm_pin`  out  4  PIN presented to the core.
- `atm_dest_acc_number`  out  12  transfer destination account.
- `atm_menu_option`  out  3  core option code, values 3–7.
- `atm_amount`  out  11  amount for withdraw, transfer or deposit.
- `atm_op_valid`  out  1  one-cycle request strobe to the core.
- `atm_exit`  out  1  one-cycle session-exit strobe.
- `atm_error`  in  1  core error flag.
- `atm_balance`  in  11  core balance.
- `disp_balance`  out  11  latched core balance.
- `disp_error`  out  1  sticky error: set by a core error or a local entry error; cleared by the next accepted key.
- `busy`  out  1  high in ISSUE and WAIT; keys are dropped while high.
- `state`  out  4  current FSM state, for debug.

## Operation
- FSM states and encodings: ACC=0, PIN=1, MENU=2, AMT=3, DEST=4, ISSUE=5, WAIT=6.
- Digit keys accumulate into a working register: `val = val*10 + digit`. Accumulation uses 17-bit internal width.
- Each field has a max value and a max digit count:
  - account and destination: 4095, 4 digits
  - PIN: 15, 2 digits
  - amount: 2047, 4 digits
  - option: 7, 1 digit
- Entry overflow:
  - A digit beyond the field's max digit count is dropped and sets an overflow flag.
  - A value exceeding the field max also sets the overflow flag.
  - ENTER with the overflow flag set, or with zero digits entered: set `disp_error`, clear the working register, stay in the same state.
- CLEAR: zero the working register and the overflow flag; no state change.
- ACC + valid ENTER: load `atm_acc_number`, go to PIN.
- PIN + valid ENTER: load `atm_pin`, go to MENU.
  - The core authenticates combinationally from these fields; this block does not check credentials.
- MENU + valid ENTER, by option:
  - 3 (balance): go to ISSUE.
  - 4, 5, 7 (withdraw, withdraw+show, deposit): go to AMT.
  - 6 (transfer): go to AMT.
  - 0–2: set `disp_error`, stay in MENU.
- AMT + valid ENTER: load `atm_amount`.
  - Option 6: go to DEST.
  - Any other option: go to ISSUE.
- DEST + valid ENTER: load `atm_dest_acc_number`, go to ISSUE.
- ISSUE: assert `atm_op_valid` for exactly one cycle, go to WAIT.
- WAIT: count `RESP_LAT` cycles, then latch `disp_balance`=`atm_balance` and `disp_error`=`atm_error`, and return to MENU.
- CANCEL in any state except ISSUE/WAIT:
  - pulse `atm_exit` for one cycle;
  - clear all `atm_*` fields, the working register and the overflow flag;
  - go to ACC.
  - `disp_balance` holds its value.
- Request fields hold stable from load until the next load or cancel.

## Timing
- Reset: all outputs 0, `state`=ACC, working register 0.
- One key is processed per cycle. A key in ISSUE/WAIT is dropped with no side effect, including CANCEL.
- Latencies:
  - ENTER accepted at cycle N: field updates and state changes at N+1.
  - Final ENTER at cycle N: `atm_op_valid` high in cycle N+1.
  - Response latched at N+1+`RESP_LAT`.
  - `busy` is high from N+1 through the latch cycle inclusive.
- `atm_exit` is high in the cycle after CANCEL is sampled.
- Reset asserted mid-request aborts immediately. No `atm_exit` pulse is produced.

## Configuration
- `ATM_FE_TIMEOUT_EN` defined:
  - a 16-bit inactivity counter runs in every state except ACC, ISSUE and WAIT;
  - it resets on any accepted key;
  - on reaching `TIMEOUT_CYCLES`, behave exactly as CANCEL.
- Undefined: no counter; a session persists indefinitely.

## Structure
- Shared package `atm_pkg`:
  - option codes BALANCE=3, WITHDRAW=4, WITHDRAW_SHOW_BALANCE=5, TRANSACTION=6, DEPOSIT=7;
  - key codes;
  - FSM state encodings;
  - per-field max value and digit-count constants.
- One sub-module, `atm_fe_digit_acc`: decimal accumulator with digit counter, overflow flag, clear input and current max-value/digit-limit inputs.

## Test plan
- Keys 2,1,7,8,ENTER,4,ENTER -> `atm_acc_number`=2178, `atm_pin`=4, `state`=MENU, no strobes.
- Then keys 5,ENTER,1,0,0,ENTER -> one-cycle `atm_op_valid` with option 5, `atm_amount`=100. Core drives balance 1900 -> `disp_balance`=1900 exactly `RESP_LAT` cycles later.
- Option 4, amount keys 2,5,5,0,ENTER -> `disp_error`=1, no `atm_op_valid`, state stays AMT. Then CLEAR,5,0,ENTER -> request issued with amount 50.
- Option 6, amount 50, dest 2,8,1,6 -> `atm_dest_acc_number`=2816, option 6, single strobe. Keys pressed while `busy` is high are ignored.
- CANCEL in MENU -> `atm_exit` pulse one cycle later, all `atm_*` fields 0, `state`=ACC. Re-login 2816/6, option 3 -> balance request issued.
- With `ATM_FE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: idle 20 cycles in MENU -> `atm_exit` pulse, `state`=ACC. Without the macro, the same idle period leaves the block in MENU.
